// File: rtl/stopclock_ctrl.sv
// stopclock_ctrl: pushbutton front end and start/stop/clear/freeze FSM for a stopwatch.
// Define STOPCLOCK_CTRL_DEBOUNCE_EN to build the per-button debouncers; without it the
// synchronised button level is used directly as the stable level.
module stopclock_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CTR_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button0,
    input  logic       button1,
    input  logic       button2,
    output logic       run,
    output logic       clear,
    output logic       freeze,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_t;

    state_t     state_r, state_n;
    logic       run_n, clear_n, freeze_n;
    logic [2:0] raw, sync1, sync2, stable, stable_d, press;

    assign raw   = {button2, button1, button0};
    assign press = stable_d & ~stable;
    assign state = state_r;

    // Two-flop synchroniser per button; idle level of an active-low button is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef STOPCLOCK_CTRL_DEBOUNCE_EN
    logic [CTR_W-1:0] cnt [3];

    // Stable level follows the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
            stable <= '1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CTR_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign stable = sync2;
`endif

    // Delayed stable level; a 1->0 step between the two is a press event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stable_d <= '1;
        else        stable_d <= stable;
    end

    // State and outputs are registered together so run/clear/freeze move on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            run     <= 1'b0;
            clear   <= 1'b0;
            freeze  <= 1'b0;
        end else begin
            state_r <= state_n;
            run     <= run_n;
            clear   <= clear_n;
            freeze  <= freeze_n;
        end
    end

    // Clear beats start/stop; freeze toggles only outside IDLE and is dropped on entering IDLE.
    always_comb begin
        state_n  = state_r;
        clear_n  = 1'b0;
        if (press[1]) begin
            state_n = IDLE;
            clear_n = 1'b1;
        end else if (press[0]) begin
            state_n = (state_r == RUN) ? STOP : RUN;
        end
        run_n    = (state_n == RUN);
        freeze_n = (state_n == IDLE) ? 1'b0 :
                   (press[2] && state_r != IDLE) ? ~freeze : freeze;
    end
endmodule

// File: tb/tb_stopclock_ctrl.sv
// tb_stopclock_ctrl: scoreboard bench for stopclock_ctrl with DEBOUNCE_CYCLES=4.
module tb_stopclock_ctrl;
    localparam int DC = 4;
`ifdef STOPCLOCK_CTRL_DEBOUNCE_EN
    localparam int L = DC + 3;
`else
    localparam int L = 3;
`endif
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STOP = 2'b10;

    typedef struct {
        string      tag;
        int         due;
        logic [4:0] val;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       button0 = 1'b1, button1 = 1'b1, button2 = 1'b1;
    logic       run, clear, freeze;
    logic [1:0] state;
    int         cyc = 0, checks = 0, errors = 0;
    exp_t       q[$];

    stopclock_ctrl #(.DEBOUNCE_CYCLES(DC), .CTR_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .button0(button0), .button1(button1), .button2(button2),
        .run(run), .clear(clear), .freeze(freeze), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [4:0] outs();
        return {state, run, clear, freeze};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic expect_at(input string tag, input int due, input logic [1:0] st,
                             input logic r, input logic c, input logic f);
        exp_t e;
        e.tag = tag;
        e.due = due;
        e.val = {st, r, c, f};
        q.push_back(e);
    endtask

    // Scoreboard: compare every entry that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                chk(q[i].tag, 32'(outs()), 32'(q[i].val));
                q.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        {button2, button1, button0} = ~m;
        tick(hold);
        {button2, button1, button0} = 3'b111;
        tick(L + 3);
    endtask

    initial begin
        int c;
        tick(3);
        chk("reset", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        tick(2);
`ifdef STOPCLOCK_CTRL_DEBOUNCE_EN
        c = cyc;
        for (int k = 1; k <= 10; k++) expect_at("short_pulse", c + k, S_IDLE, 0, 0, 0);
        press(3'b001, 3);
`endif
        c = cyc;
        expect_at("start_pre", c + L - 1, S_IDLE, 0, 0, 0);
        expect_at("start_run", c + L, S_RUN, 1, 0, 0);
        press(3'b001, 20);
        expect_at("start_once", cyc, S_RUN, 1, 0, 0);
        c = cyc;
        expect_at("stop", c + L, S_STOP, 0, 0, 0);
        press(3'b001, L + 2);
        c = cyc;
        expect_at("restart", c + L, S_RUN, 1, 0, 0);
        press(3'b001, L + 2);
        c = cyc;
        expect_at("both_idle", c + L, S_IDLE, 0, 1, 0);
        expect_at("both_clr_end", c + L + 1, S_IDLE, 0, 0, 0);
        press(3'b011, L + 2);
        c = cyc;
        expect_at("run_again", c + L, S_RUN, 1, 0, 0);
        press(3'b001, L + 2);
        c = cyc;
        expect_at("freeze_on", c + L, S_RUN, 1, 0, 1);
        press(3'b100, L + 2);
        c = cyc;
        expect_at("clr_unfreeze", c + L, S_IDLE, 0, 1, 0);
        expect_at("clr_pulse_end", c + L + 1, S_IDLE, 0, 0, 0);
        press(3'b010, L + 2);
        c = cyc;
        expect_at("freeze_idle_ignored", c + L, S_IDLE, 0, 0, 0);
        press(3'b100, L + 2);
        c = cyc;
        expect_at("run_pre_reset", c + L, S_RUN, 1, 0, 0);
        press(3'b001, L + 2);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'h0);
        tick(2);
        rst_n = 1'b1;
        c = cyc;
        expect_at("post_reset_1", c + 1, S_IDLE, 0, 0, 0);
        expect_at("post_reset_2", c + 2, S_IDLE, 0, 0, 0);
        tick(3);
        button0 = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        c = cyc;
        expect_at("held_reset_pre", c + L - 1, S_IDLE, 0, 0, 0);
        expect_at("held_reset_run", c + L, S_RUN, 1, 0, 0);
        expect_at("held_reset_once", c + L + 8, S_RUN, 1, 0, 0);
        tick(L + 9);
        button0 = 1'b1;
        tick(L + 5);
        chk("pending", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
